// File: rtl/alu_multicycle.sv
// Multi-cycle ALU for the RV32 datapath. Most ops take one cycle. MUL/MULHU use an
// iterative shift-add engine and DIVU/REMU use a restoring divider, each taking WIDTH cycles.
module alu_multicycle #(
  parameter int WIDTH         = 32,
  parameter int ENABLE_MULDIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start_i,
  input  logic [3:0]       ALU_Operation_i,
  input  logic [WIDTH-1:0] A_i,
  input  logic [WIDTH-1:0] B_i,
  output logic             Busy_o,
  output logic             Done_o,
  output logic             Zero_o,
  output logic [WIDTH-1:0] ALU_Result_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_p0, state_n;
  logic [CNT_W-1:0] cnt_p0, cnt_n;
  logic             vld_p1, vld_n;
  logic [WIDTH-1:0] result_p1, result_n;
  logic             zero_p1, zero_n;
  logic [WIDTH-1:0] hi_p0, hi_n, lo_p0, lo_n, opb_p0, opb_n;
  logic             sel_hi_p0, sel_hi_n;
  logic [2*WIDTH-1:0] step;
  logic             is_md;

  function automatic logic [WIDTH-1:0] fast_alu(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic [CNT_W-1:0]        sh;
    logic signed [WIDTH-1:0] a_s, b_s;
    sh  = b[CNT_W-1:0];
    a_s = a;
    b_s = b;
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0010: return a | b;
      4'b0011: return a & b;
      4'b0100: return {b[WIDTH-13:0], 12'b0};
      4'b0101: return a << sh;
      4'b0110: return a >> sh;
      4'b0111: return a_s >>> sh;
      4'b1000: return a ^ b;
      4'b1001: return (a_s < b_s) ? WIDTH'(1) : '0;
      4'b1010: return (a < b) ? WIDTH'(1) : '0;
      default: return '0;
    endcase
  endfunction

  // {hi,lo} shifts right each step: hi collects partial sums, lo drains the multiplier bits.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, hi} + {1'b0, {WIDTH{lo[0]}} & b};
    return {sum, lo[WIDTH-1:1]};
  endfunction

  // hi is the partial remainder; lo shifts dividend bits out and quotient bits in.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] hi,
                                                  input logic [WIDTH-1:0] lo,
                                                  input logic [WIDTH-1:0] b);
    logic [WIDTH:0] rs, diff;
    rs   = {hi, lo[WIDTH-1]};
    diff = rs - {1'b0, b};
    if (diff[WIDTH]) return {rs[WIDTH-1:0], lo[WIDTH-2:0], 1'b0};
    return {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
  endfunction

  assign is_md = (ENABLE_MULDIV != 0) && (ALU_Operation_i[3:2] == 2'b11);

  always_comb begin
    state_n  = state_p0;
    cnt_n    = cnt_p0;
    vld_n    = 1'b0;
    result_n = result_p1;
    zero_n   = zero_p1;
    hi_n     = hi_p0;
    lo_n     = lo_p0;
    opb_n    = opb_p0;
    sel_hi_n = sel_hi_p0;
    step     = '0;
    case (state_p0)
      S_IDLE: begin
        if (Start_i) begin
          if (is_md) begin
            state_n  = ALU_Operation_i[1] ? S_DIV : S_MUL;
            cnt_n    = '0;
            hi_n     = '0;
            lo_n     = A_i;
            opb_n    = B_i;
            sel_hi_n = ALU_Operation_i[0];
          end else begin
            result_n = fast_alu(ALU_Operation_i, A_i, B_i);
            zero_n   = (result_n == '0);
            vld_n    = 1'b1;
          end
        end
      end
      S_MUL, S_DIV: begin
        step  = (state_p0 == S_MUL) ? mul_step(hi_p0, lo_p0, opb_p0)
                                    : div_step(hi_p0, lo_p0, opb_p0);
        hi_n  = step[2*WIDTH-1:WIDTH];
        lo_n  = step[WIDTH-1:0];
        cnt_n = cnt_p0 + 1'b1;
        if (cnt_p0 == LAST) begin
          // MULHU/REMU take the high half, MUL/DIVU the low half.
          state_n  = S_IDLE;
          cnt_n    = '0;
          result_n = sel_hi_p0 ? hi_n : lo_n;
          zero_n   = (result_n == '0);
          vld_n    = 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Stage p0 -> p1: control and result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0  <= S_IDLE;
      cnt_p0    <= '0;
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      zero_p1   <= 1'b1;
    end else begin
      state_p0  <= state_n;
      cnt_p0    <= cnt_n;
      vld_p1    <= vld_n;
      result_p1 <= result_n;
      zero_p1   <= zero_n;
    end
  end

  always_ff @(posedge clk) begin
    hi_p0     <= hi_n;
    lo_p0     <= lo_n;
    opb_p0    <= opb_n;
    sel_hi_p0 <= sel_hi_n;
  end

  assign Busy_o       = (state_p0 != S_IDLE);
  assign Done_o       = vld_p1;
  assign Zero_o       = zero_p1;
  assign ALU_Result_o = result_p1;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: vector table plus hand sequences, with results checked
// through an in-order scoreboard of expected values.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        reset, start, start0;
  logic [3:0]  op, op0;
  logic [31:0] a, b, a0, b0;
  logic        busy, done, zero, busy0, done0, zero0;
  logic [31:0] res, res0;

  alu_multicycle #(.WIDTH(32), .ENABLE_MULDIV(1)) dut (
    .clk(clk), .reset(reset), .Start_i(start), .ALU_Operation_i(op), .A_i(a), .B_i(b),
    .Busy_o(busy), .Done_o(done), .Zero_o(zero), .ALU_Result_o(res));

  alu_multicycle #(.WIDTH(32), .ENABLE_MULDIV(0)) dut0 (
    .clk(clk), .reset(reset), .Start_i(start0), .ALU_Operation_i(op0), .A_i(a0), .B_i(b0),
    .Busy_o(busy0), .Done_o(done0), .Zero_o(zero0), .ALU_Result_o(res0));

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          slow;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          busy0_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic mon();
    logic [31:0] e;
    if (done) begin
      chk("done_has_request", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("result", res, e);
        chk("zero", {31'b0, zero}, {31'b0, e == 32'd0});
      end
    end
    if (busy0) busy0_seen = 1'b1;
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
  endtask

  task automatic run_fast(input vec_t v);
    @(negedge clk);
    drive(v.op, v.a, v.b);
    exp_q.push_back(v.exp);
    @(negedge clk);
    start = 1'b0;
    chk("fast_latency", {31'b0, done}, 32'd1);
  endtask

  task automatic run_slow(input vec_t v);
    int nb;
    @(negedge clk);
    drive(v.op, v.a, v.b);
    exp_q.push_back(v.exp);
    @(negedge clk);
    start = 1'b0;
    nb = 0;
    for (int t = 0; t < 100 && !done; t++) begin
      if (busy) nb++;
      @(negedge clk);
    end
    chk("slow_done_seen", {31'b0, done}, 32'd1);
    chk("busy_cycles", 32'(nb), 32'd32);
  endtask

  task automatic wait_done(input string name);
    for (int t = 0; t < 100 && !done; t++) @(negedge clk);
    chk(name, {31'b0, done}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    reset = 1'b1; start = 1'b0; start0 = 1'b0;
    op = '0; a = '0; b = '0; op0 = '0; a0 = '0; b0 = '0;

    vecs.push_back('{4'b0000, 32'd5,        32'hFFFFFFF9, 32'hFFFFFFFE, 1'b0});
    vecs.push_back('{4'b0001, 32'd9,        32'd9,        32'h00000000, 1'b0});
    vecs.push_back('{4'b0000, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0});
    vecs.push_back('{4'b0001, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{4'b0010, 32'h0000F0F0, 32'h00000F0F, 32'h0000FFFF, 1'b0});
    vecs.push_back('{4'b0011, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0});
    vecs.push_back('{4'b1000, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0});
    vecs.push_back('{4'b0101, 32'd1,        32'd31,       32'h80000000, 1'b0});
    vecs.push_back('{4'b0101, 32'd1,        32'd33,       32'h00000002, 1'b0});
    vecs.push_back('{4'b0110, 32'h80000000, 32'd31,       32'h00000001, 1'b0});
    vecs.push_back('{4'b0111, 32'h80000000, 32'd4,        32'hF8000000, 1'b0});
    vecs.push_back('{4'b1001, 32'd1,        32'hFFFFFFFF, 32'h00000000, 1'b0});
    vecs.push_back('{4'b1001, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0});
    vecs.push_back('{4'b1010, 32'd1,        32'hFFFFFFFF, 32'h00000001, 1'b0});
    vecs.push_back('{4'b1011, 32'd3,        32'd4,        32'h00000000, 1'b0});
    vecs.push_back('{4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1});
    vecs.push_back('{4'b1101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1});
    vecs.push_back('{4'b1100, 32'd12345,    32'd6789,     32'h04FED79D, 1'b1});
    vecs.push_back('{4'b1101, 32'h80000000, 32'd4,        32'h00000002, 1'b1});
    vecs.push_back('{4'b1110, 32'd100,      32'd7,        32'd14,       1'b1});
    vecs.push_back('{4'b1111, 32'd100,      32'd7,        32'd2,        1'b1});
    vecs.push_back('{4'b1110, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1});
    vecs.push_back('{4'b1111, 32'd5,        32'd0,        32'd5,        1'b1});
    vecs.push_back('{4'b1110, 32'd7,        32'd100,      32'd0,        1'b1});
    vecs.push_back('{4'b1111, 32'hFFFFFFFF, 32'd10,       32'd5,        1'b1});

    fork
      forever begin
        @(negedge clk);
        mon();
      end
      begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", res, 32'd0);
        chk("rst_zero", {31'b0, zero}, 32'd1);
        reset = 1'b0;

        foreach (vecs[i]) begin
          if (vecs[i].slow) run_slow(vecs[i]);
          else              run_fast(vecs[i]);
        end

        // Back-to-back single-cycle ops, one accepted per clock
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          if (i > 0) chk("b2b_done", {31'b0, done}, 32'd1);
          case (i)
            0: begin drive(4'b0100, 32'd0, 32'h00012345);        exp_q.push_back(32'h12345000); end
            1: begin drive(4'b0111, 32'h80000000, 32'd4);         exp_q.push_back(32'hF8000000); end
            2: begin drive(4'b1001, 32'hFFFFFFFF, 32'd1);         exp_q.push_back(32'd1);        end
            default: begin drive(4'b1010, 32'hFFFFFFFF, 32'd1);   exp_q.push_back(32'd0);        end
          endcase
        end
        @(negedge clk);
        start = 1'b0;
        chk("b2b_done_last", {31'b0, done}, 32'd1);
        @(negedge clk);
        chk("idle_no_done", {31'b0, done}, 32'd0);

        // New start issued in the Done_o cycle of a multiply
        @(negedge clk);
        drive(4'b1100, 32'd3, 32'd5);
        exp_q.push_back(32'd15);
        @(negedge clk);
        start = 1'b0;
        wait_done("mul_done");
        drive(4'b0000, 32'd2, 32'd2);
        exp_q.push_back(32'd4);
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_cycle", {31'b0, done}, 32'd1);
        chk("start_in_done_busy", {31'b0, busy}, 32'd0);

        // Start while busy must be ignored
        @(negedge clk);
        drive(4'b1110, 32'd100, 32'd7);
        exp_q.push_back(32'd14);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        drive(4'b0000, 32'd1, 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_ignores_start", {31'b0, busy}, 32'd1);
        wait_done("div_done");

        // Reset mid-division aborts without a Done_o
        @(negedge clk);
        drive(4'b1110, 32'd1000, 32'd3);
        exp_q.push_back(32'd333);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", res, 32'd0);
        chk("abort_zero", {31'b0, zero}, 32'd1);
        repeat (40) @(negedge clk);
        v = '{4'b0000, 32'd1, 32'd1, 32'd2, 1'b0};
        run_fast(v);

        // ENABLE_MULDIV=0 instance: MUL behaves as an undefined single-cycle op
        @(negedge clk);
        start0 = 1'b1; op0 = 4'b0000; a0 = 32'd3; b0 = 32'd4;
        @(negedge clk);
        start0 = 1'b0;
        chk("nomd_add_done", {31'b0, done0}, 32'd1);
        chk("nomd_add_result", res0, 32'd7);
        @(negedge clk);
        start0 = 1'b1; op0 = 4'b1100;
        @(negedge clk);
        start0 = 1'b0;
        chk("nomd_mul_done", {31'b0, done0}, 32'd1);
        chk("nomd_mul_busy", {31'b0, busy0}, 32'd0);
        chk("nomd_mul_result", res0, 32'd0);
        chk("nomd_mul_zero", {31'b0, zero0}, 32'd1);
        repeat (3) @(negedge clk);
        chk("nomd_never_busy", {31'b0, busy0_seen}, 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    join_any
  end

endmodule
